// File: rtl/banked_regfile_mp.sv
// banked_regfile_mp: ARM banked register file (33 physical regs + PC), multi-read-port, with bank-scrub engine.
// Define REGFILE_BYPASS_EN to forward same-cycle writes (and pc_we) to matching reads.
module banked_regfile_mp #(
    parameter int                DATA_W  = 32,
    parameter int                NUM_RD  = 3,
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [4:0]               M,
    input  logic [4*NUM_RD-1:0]      rd_addr,
    output logic [DATA_W*NUM_RD-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_err,
    input  logic                     wr_en,
    input  logic [3:0]               wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     pc_we,
    input  logic [DATA_W-1:0]        pc_wdata,
    input  logic                     scrub_req,
    input  logic [4:0]               scrub_mode,
    output logic                     scrub_busy,
    output logic                     scrub_done,
    output logic                     wr_err,
    output logic                     err_sticky,
    input  logic                     err_clr
);
    localparam logic [4:0] USR = 5'b10000, FIQ = 5'b10001, IRQ = 5'b10010, SVC = 5'b10011,
                           MON = 5'b10110, ABT = 5'b10111, HYP = 5'b11010, UND = 5'b11011,
                           SYS = 5'b11111;

    typedef enum logic [1:0] {IDLE, SCRUB, DONE} state_t;

    function automatic logic mode_ok(input logic [4:0] m);
        return m inside {USR, FIQ, IRQ, SVC, MON, ABT, HYP, UND, SYS};
    endfunction

    // Physical layout: 0-7 r0-r7, 8-12 r8-r12, 13/14 usr, 15-21 fiq r8-r14,
    // 22-31 r13/r14 pairs for irq/svc/mon/abt/und, 32 hyp r13. Returns {legal, index}.
    function automatic logic [6:0] map_reg(input logic [4:0] m, input logic [3:0] a);
        logic [5:0] base;
        logic [5:0] ax;
        logic [5:0] idx;
        logic       ok;
        ax = {2'b00, a};
        ok = mode_ok(m) && a != 4'd15 && !(m == HYP && a == 4'd14);
        case (m)
            FIQ:     base = 6'd20;
            IRQ:     base = 6'd22;
            SVC:     base = 6'd24;
            MON:     base = 6'd26;
            ABT:     base = 6'd28;
            UND:     base = 6'd30;
            HYP:     base = 6'd32;
            default: base = 6'd13;
        endcase
        idx = (a < 4'd8) ? ax : (a < 4'd13) ? ((m == FIQ) ? ax + 6'd7 : ax) : base + ax - 6'd13;
        return {ok, ok ? idx : 6'd0};
    endfunction

    logic [DATA_W-1:0] regs [0:32];
    logic [DATA_W-1:0] pc;
    state_t            state;
    logic [4:0]        s_mode;
    logic [3:0]        s_addr;
    logic [3:0]        s_last;
    logic [6:0]        wr_map;
    logic [6:0]        s_map;
    logic              wr_ok;
    logic              wr_rej;
    logic              scrub_bad;

    assign wr_map    = map_reg(M, wr_addr);
    assign s_map     = map_reg(s_mode, s_addr);
    assign wr_ok     = wr_en && state == IDLE && wr_map[6];
    assign wr_rej    = wr_en && !wr_ok;
    assign scrub_bad = scrub_req && state == IDLE && !mode_ok(scrub_mode);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            s_mode     <= USR;
            s_addr     <= '0;
            s_last     <= '0;
            scrub_busy <= 1'b0;
            scrub_done <= 1'b0;
        end else begin
            case (state)
                IDLE: if (scrub_req && mode_ok(scrub_mode)) begin
                    state      <= SCRUB;
                    scrub_busy <= 1'b1;
                    s_mode     <= scrub_mode;
                    s_addr     <= (scrub_mode == FIQ) ? 4'd8 : (scrub_mode == USR || scrub_mode == SYS) ? 4'd0 : 4'd13;
                    s_last     <= (scrub_mode == HYP) ? 4'd13 : 4'd14;
                end
                SCRUB: if (s_addr == s_last) begin
                    state      <= DONE;
                    scrub_done <= 1'b1;
                end else begin
                    s_addr <= s_addr + 4'd1;
                end
                default: begin
                    state      <= IDLE;
                    scrub_busy <= 1'b0;
                    scrub_done <= 1'b0;
                end
            endcase
        end
    end

    // User writes are only accepted in IDLE, so they never collide with a scrub clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 33; k++) regs[k] <= RST_VAL;
            pc <= RST_VAL;
        end else begin
            if (pc_we) pc <= pc_wdata;
            if (wr_ok) regs[wr_map[5:0]] <= wr_data;
            if (state == SCRUB) regs[s_map[5:0]] <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_err     <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            wr_err     <= wr_rej | scrub_bad;
            err_sticky <= (err_sticky & ~err_clr) | wr_rej | scrub_bad | (|rd_err);
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [3:0]        a;
        logic [6:0]        mr;
        logic [DATA_W-1:0] v;
        assign a         = rd_addr[4*i +: 4];
        assign mr        = map_reg(M, a);
        assign rd_err[i] = !mode_ok(M) || (a != 4'd15 && !mr[6]);
`ifdef REGFILE_BYPASS_EN
        assign v = (a == 4'd15) ? (pc_we ? pc_wdata : pc) :
                   (wr_ok && wr_map[5:0] == mr[5:0]) ? wr_data : regs[mr[5:0]];
`else
        assign v = (a == 4'd15) ? pc : regs[mr[5:0]];
`endif
        assign rd_data[DATA_W*i +: DATA_W] = rd_err[i] ? '0 : v;
    end
endmodule
